// File: rtl/fsm_ring_if.sv
// Bundle of control inputs and state outputs for the fsm_ring ring state machine.
// The stalls field exists only when FSM_RING_STALL_CNT_EN is defined.
interface fsm_ring_if #(
  parameter int NUM_STATES = 3,
  parameter int STATE_W    = 2,
  parameter int LAP_W      = 8
);
  localparam int IDX_W = $clog2(NUM_STATES > 1 ? NUM_STATES : 2);

  logic                          en;
  logic                          dir;
  logic [NUM_STATES-1:0]         i;
  logic [NUM_STATES*STATE_W-1:0] c;
  logic [STATE_W-1:0]            a;
  logic [STATE_W-1:0]            y;
  logic [IDX_W-1:0]              idx;
  logic                          wrap;
  logic [LAP_W-1:0]              laps;
`ifdef FSM_RING_STALL_CNT_EN
  logic [15:0]                   stalls;

  modport master (output en, dir, i, c, a, input y, idx, wrap, laps, stalls);
  modport slave  (input en, dir, i, c, a, output y, idx, wrap, laps, stalls);
`else
  modport master (output en, dir, i, c, a, input y, idx, wrap, laps);
  modport slave  (input en, dir, i, c, a, output y, idx, wrap, laps);
`endif
endinterface

// File: rtl/fsm_ring.sv
// N-state ring state machine with per-state guards, programmable codes, direction,
// wrap pulse and lap counter. Optional stall counter under FSM_RING_STALL_CNT_EN.
module fsm_ring #(
  parameter int NUM_STATES = 3,
  parameter int STATE_W    = 2,
  parameter int LAP_W      = 8
) (
  input  logic      clock,
  input  logic      reset,
  fsm_ring_if.slave bus
);
  localparam int               IDX_W = $clog2(NUM_STATES > 1 ? NUM_STATES : 2);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_STATES - 1);

  logic [STATE_W-1:0] codes [NUM_STATES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_slot
      assign codes[gi] = bus.c[gi*STATE_W +: STATE_W];
    end
  endgenerate

  logic [IDX_W-1:0]   idx_q, idx_d, idx_cur, idx_step;
  logic [STATE_W-1:0] y_q, y_d;
  logic               wrap_q, wrap_d;
  logic [LAP_W-1:0]   laps_q, laps_d;
  logic               guard, adv, at_edge;

  always_comb begin
    // An index past the last slot can only come from corruption; treat it as slot 0.
    idx_cur  = (idx_q > LAST) ? '0 : idx_q;
    guard    = 1'b0;
    y_d      = codes[0];
    at_edge  = 1'b0;
    idx_step = idx_cur;

    for (int k = 0; k < NUM_STATES; k++) begin
      if (idx_cur == IDX_W'(k)) guard = bus.i[k];
    end

    // Compared against the registered code so a stale feedback path stalls the ring.
    adv = bus.en & guard & (bus.a == y_q);

    if (bus.dir) begin
      at_edge  = (idx_cur == '0);
      idx_step = at_edge ? LAST : idx_cur - 1'b1;
    end else begin
      at_edge  = (idx_cur == LAST);
      idx_step = at_edge ? '0 : idx_cur + 1'b1;
    end

    idx_d  = adv ? idx_step : idx_cur;
    wrap_d = adv & at_edge;
    laps_d = wrap_d ? laps_q + 1'b1 : laps_q;

    for (int k = 0; k < NUM_STATES; k++) begin
      if (idx_d == IDX_W'(k)) y_d = codes[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      y_q    <= codes[0];
      wrap_q <= 1'b0;
      laps_q <= '0;
    end else begin
      idx_q  <= idx_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
      laps_q <= laps_d;
    end
  end

  assign bus.idx  = idx_q;
  assign bus.y    = y_q;
  assign bus.wrap = wrap_q;
  assign bus.laps = laps_q;

`ifdef FSM_RING_STALL_CNT_EN
  logic [15:0] stalls_q, stalls_d;

  always_comb begin
    stalls_d = stalls_q;
    if (bus.en && !adv && stalls_q != 16'hFFFF) stalls_d = stalls_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stalls_q <= '0;
    else       stalls_q <= stalls_d;
  end

  assign bus.stalls = stalls_q;
`endif
endmodule

// File: tb/tb_fsm_ring.sv
// Self-checking bench for fsm_ring: directed scenarios then randomized traffic,
// checked against an arithmetic ring model. A second instance uses a 2-bit lap counter.
module tb_fsm_ring;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int LW = 8;

  logic clock = 1'b0;
  logic reset_r;
  always #5 clock = ~clock;

  logic              en_r, dir_r, a_fb;
  logic [N-1:0]      i_r;
  logic [N*SW-1:0]   c_r;
  logic [SW-1:0]     a_val;

  fsm_ring_if #(.NUM_STATES(N), .STATE_W(SW), .LAP_W(LW)) bus  ();
  fsm_ring_if #(.NUM_STATES(N), .STATE_W(SW), .LAP_W(2))  bus2 ();

  fsm_ring #(.NUM_STATES(N), .STATE_W(SW), .LAP_W(LW)) dut (
    .clock (clock),
    .reset (reset_r),
    .bus   (bus.slave)
  );

  fsm_ring #(.NUM_STATES(N), .STATE_W(SW), .LAP_W(2)) dut2 (
    .clock (clock),
    .reset (reset_r),
    .bus   (bus2.slave)
  );

  assign bus.en   = en_r;
  assign bus.dir  = dir_r;
  assign bus.i    = i_r;
  assign bus.c    = c_r;
  assign bus.a    = a_fb ? bus.y : a_val;
  assign bus2.en  = en_r;
  assign bus2.dir = dir_r;
  assign bus2.i   = i_r;
  assign bus2.c   = c_r;
  assign bus2.a   = a_fb ? bus2.y : a_val;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Reference state: ring position, code, pulse and lap count as plain integers.
  int m_idx, m_y, m_wrap, m_laps, m_stalls;

  function automatic int slot(input int k);
    return int'((c_r >> (k * SW)) & ((1 << SW) - 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  // Inputs are set at the falling edge before calling; one rising edge is consumed.
  task automatic step(input logic rst);
    int  a_eff;
    bit  adv, crossing;
    a_eff = a_fb ? m_y : int'(a_val);
    if (rst) begin
      m_idx = 0; m_wrap = 0; m_laps = 0; m_stalls = 0;
    end else begin
      adv = en_r && i_r[m_idx] && (a_eff == m_y);
      if (adv) begin
        crossing = dir_r ? (m_idx == 0) : (m_idx == N - 1);
        m_idx    = (m_idx + (dir_r ? N - 1 : 1)) % N;
        m_wrap   = crossing;
        if (crossing) m_laps = m_laps + 1;
      end else begin
        m_wrap = 0;
        if (en_r && m_stalls < 65535) m_stalls = m_stalls + 1;
      end
    end
    m_y = slot(m_idx);
    reset_r = rst;
    @(posedge clock);
    @(negedge clock);
    step_no++;
    $display("step %0d rst=%0b en=%0b dir=%0b i=%b c=%h y=%0d idx=%0d wrap=%0b laps=%0d",
             step_no, rst, en_r, dir_r, i_r, c_r, bus.y, bus.idx, bus.wrap, bus.laps);
    check("y",     32'(bus.y),     32'(m_y));
    check("idx",   32'(bus.idx),   32'(m_idx));
    check("wrap",  32'(bus.wrap),  32'(m_wrap));
    check("laps",  32'(bus.laps),  32'(m_laps % 256));
    check("laps2", 32'(bus2.laps), 32'(m_laps % 4));
    check("y2",    32'(bus2.y),    32'(m_y));
`ifdef FSM_RING_STALL_CNT_EN
    check("stalls", 32'(bus.stalls), 32'(m_stalls));
`endif
  endtask

  initial begin
    reset_r = 1'b1;
    en_r = 1'b1; dir_r = 1'b0; i_r = '1; a_fb = 1'b1; a_val = '0;
    c_r = {2'd2, 2'd1, 2'd0};
    m_idx = 0; m_y = 0; m_wrap = 0; m_laps = 0; m_stalls = 0;
    @(negedge clock);

    step(1'b1); step(1'b1);
    check("reset_y_is_0", 32'(bus.y), 32'd0);

    // Five forward loops: y 1,2,0,... with a wrap on each return to 0.
    for (int s = 0; s < 15; s++) step(1'b0);
    check("fwd_laps_5", 32'(bus.laps), 32'd5);
    check("fwd_laps2_5", 32'(bus2.laps), 32'd1);

    en_r = 1'b0;
    step(1'b0); step(1'b0);
    en_r = 1'b1;

    step(1'b1);
    dir_r = 1'b1;
    for (int s = 0; s < 7; s++) step(1'b0);
    dir_r = 1'b0;

    step(1'b1);
    i_r = 3'b101;
    for (int s = 0; s < 6; s++) step(1'b0);
    check("guard_hold_y", 32'(bus.y), 32'd1);
    i_r = '1;

    step(1'b1);
    a_fb = 1'b0; a_val = 2'd3;
    for (int s = 0; s < 5; s++) step(1'b0);
    a_fb = 1'b1;

    // Reset while sitting at code 2 with advance true.
    step(1'b1); step(1'b0); step(1'b0);
    check("pre_reset_y_2", 32'(bus.y), 32'd2);
    step(1'b1);
    check("mid_reset_wrap", 32'(bus.wrap), 32'd0);
    step(1'b0); step(1'b0);

    // Duplicate codes advance on consecutive cycles.
    c_r = {2'd1, 2'd1, 2'd1};
    for (int s = 0; s < 4; s++) step(1'b0);

    for (int s = 0; s < 400; s++) begin
      en_r  = ($urandom_range(0, 5) != 0);
      dir_r = 1'($urandom);
      i_r   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
      if ($urandom_range(0, 7) == 0) c_r = (N*SW)'($urandom);
      a_fb  = ($urandom_range(0, 7) != 0);
      a_val = SW'($urandom);
      step($urandom_range(0, 40) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
